inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Reader side of the instruction memory bank.
- Owns the program counter and drives a byte address to the combinational word-indexed instruction memory, which returns `mem[addr>>2]` in the same cycle.
- Buffers fetched words in a small prefetch queue and hands {pc, instr} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; detects misaligned and out-of-range fetch addresses.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h0, PC loaded on reset.
- MEM_WORDS, 128, number of words in the instruction memory; fetch addresses with (pc>>2) >= MEM_WORDS are illegal.
- QDEPTH, 2, prefetch queue depth; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address to the instruction memory; equals the fetch_pc register.
- imem_rdata  in  DATA_W  instruction word from memory, valid in the same cycle.
- out_valid  out  1  queue head valid toward decode.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  byte address of the head instruction.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  ADDR_W  new fetch target.
- fetch_fault  out  1  fetch halted on an illegal address.

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC; queue empty; state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
  - imem_addr=RESET_PC.
- States: RUN, FAULT. fetch_fault is 1 exactly in FAULT.
- Push condition (RUN only): !redirect_valid && legal(fetch_pc) && (count<QDEPTH || pop).
  - legal(pc) means pc[1:0]==0 and (pc>>2) < MEM_WORDS.
  - On a push edge: enqueue {fetch_pc, imem_rdata}, then fetch_pc += 4, wrapping modulo 2^ADDR_W.
- Pop condition: out_valid && out_ready. out_valid = (count!=0) && !redirect_valid, i.e. masked combinationally during a redirect.
- Simultaneous push and pop on a full queue is allowed; count is unchanged.
- Latency: an instruction fetched at edge N is presented at out_* from edge N onward (visible in cycle N+1). After rst deassert, out_valid rises after the first clock edge.
- Throughput: one instruction per cycle while out_ready=1.
- Stall: with out_ready=0 the queue fills to QDEPTH, then fetch_pc holds. imem_addr holds stable while full.
- Redirect (any state, redirect_valid=1 at an edge):
  - Queue flushed (count=0); no push, no pop that cycle.
  - If legal(redirect_pc): fetch_pc=redirect_pc, state=RUN. This clears a FAULT.
  - Else: fetch_pc=redirect_pc, state=FAULT.
  - Redirect has priority over everything except rst.
- Illegal sequential fetch: in RUN with !redirect_valid and !legal(fetch_pc), the edge moves state to FAULT.
  - No push occurs; fetch_pc holds.
  - Entries already queued still drain normally.
- In FAULT: no pushes, fetch_pc holds, imem_addr=fetch_pc. Only a legal redirect or rst leaves FAULT.
- out_instr/out_pc when out_valid=0: hold the last head contents (X-free). They are 0 after reset.
- Reset mid-operation: all queued entries are discarded immediately; no handshake completes in that cycle.

Decomposition:
- Shared package fetch_pkg:
  - state enum {FS_RUN, FS_FAULT};
  - typedef fetch_entry_t {pc[ADDR_W], instr[DATA_W]};
  - RESET_PC and MEM_WORDS defaults, shared with the instruction-memory bank.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with QDEPTH entries.
  - Inputs push, pop, flush; outputs count, head.
  - Same clk/rst convention.
- PC, legality check and the FSM stay in inst_fetch_unit.

Test Plan:
- Reset then out_ready=1, mem[0]=0x00004020, mem[1]=0x20090007 -> after the first edge out_valid=1 with pc=0x0, instr=0x00004020; next cycle pc=0x4, instr=0x20090007; one instruction per cycle.
- out_ready=0 for 5 cycles from reset -> queue holds pc 0x0 and 0x4, imem_addr stays 0x8. On out_ready=1, pops 0x0, 0x4, 0x8 on consecutive cycles with no bubble.
- Queue holds pc 0x10, 0x14; redirect_valid=1, redirect_pc=0x28 -> out_valid=0 that cycle; next cycle out_pc=0x28, instr=mem[10]; 0x10 and 0x14 are never delivered.
- Sequential fetch reaches 0x1FC (word 127) -> word 127 delivered; at fetch_pc=0x200, fetch_fault=1 and no further out_valid after the drain. Then redirect to 0x0 -> fetch_fault=0 and instr=mem[0].
- redirect_pc=0x6 -> FAULT, queue empty, out_valid stays 0. Then redirect_pc=0x8 -> recovers, out_pc=0x8.
- Assert rst for one cycle mid-stream with a full queue -> out_valid=0 and fetch_fault=0 immediately; first post-reset delivery is pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and defaults shared by the fetch unit and the instruction
// memory bank.
//   FETCH_ADDR_W / FETCH_DATA_W : byte address and instruction word widths
//   FETCH_RESET_PC              : PC loaded on reset
//   FETCH_MEM_WORDS             : instruction memory size in words
//   fetch_state_e               : fetch FSM states
//   fetch_entry_t               : one prefetch queue entry {pc, instr}
package fetch_pkg;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 32'h0;
  localparam int FETCH_MEM_WORDS = 128;

  typedef enum logic {FS_RUN, FS_FAULT} fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t used as the prefetch queue.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (caller guarantees space or pop)
//   pop        : drop the head entry (caller guarantees non-empty)
//   flush      : empty the queue; overrides push and pop
//   push_data  : entry to enqueue
//   count      : number of valid entries, 0..QDEPTH
//   head       : oldest entry; storage of the read slot when empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_data,
  output logic [$clog2(QDEPTH):0]    count,
  output fetch_entry_t               head
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // QDEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: reader side of the instruction memory bank.
// Owns the fetch PC, reads the combinational word-indexed memory, buffers
// words in a prefetch queue and hands {pc, instr} to decode.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_addr       : byte address to memory (the fetch PC)
//   imem_rdata      : word at imem_addr, same cycle
//   out_valid/ready : handshake toward decode
//   out_instr/pc    : head entry; hold last shown head when not valid
//   redirect_valid/pc : PC change request from execute
//   fetch_fault     : fetch halted on a misaligned/out-of-range address
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FETCH_ADDR_W,
  parameter int                DATA_W    = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = FETCH_RESET_PC,
  parameter int                MEM_WORDS = FETCH_MEM_WORDS,
  parameter int                QDEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  function automatic logic pc_legal(input logic [ADDR_W-1:0] pc);
    return (pc[1:0] == 2'b00) && ((pc >> 2) < ADDR_W'(MEM_WORDS));
  endfunction

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head, last_head, view, push_entry;
  logic              fetch_legal, q_full, push, pop;

  assign fetch_legal = pc_legal(fetch_pc);
  assign q_full      = (count == CNT_W'(QDEPTH));

  // A redirect masks the handshake so the flushed head is never consumed.
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = (state == FS_RUN) && !redirect_valid && fetch_legal &&
                     (!q_full || pop);

  assign push_entry = '{pc: fetch_pc, instr: imem_rdata};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .count     (count),
    .head      (head)
  );

  // The FIFO slot under an empty read pointer is stale, so remember the last
  // head actually presented and show that while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               last_head <= '0;
    else if (count != '0)  last_head <= head;
  end

  assign view      = (count != '0) ? head : last_head;
  assign out_instr = view.instr;
  assign out_pc    = view.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      state    <= FS_RUN;
    end else if (redirect_valid) begin
      // An illegal target is still latched so imem_addr shows what faulted.
      fetch_pc <= redirect_pc;
      state    <= pc_legal(redirect_pc) ? FS_RUN : FS_FAULT;
    end else if (state == FS_RUN) begin
      if (!fetch_legal)  state    <= FS_FAULT;
      else if (push)     fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  assign imem_addr   = fetch_pc;
  assign fetch_fault = (state == FS_FAULT);
endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] imem [128];

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input int i);
    if (i == 0) return 32'h00004020;
    if (i == 1) return 32'h20090007;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  always_comb begin
    imem_rdata = 32'h0;
    if ((imem_addr >> 2) < 32'd128) imem_rdata = imem[imem_addr[8:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = rdy;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %0b want 0", fetch_fault); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_pre: valid got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00004020) begin n_err++; $display("FAIL stream_0: v=%0b pc=%h instr=%h want 1/0/00004020", out_valid, out_pc, out_instr); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h20090007) begin n_err++; $display("FAIL stream_4: v=%0b pc=%h instr=%h want 1/4/20090007", out_valid, out_pc, out_instr); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== word_at(2)) begin n_err++; $display("FAIL stream_8: v=%0b pc=%h instr=%h want 1/8/%h", out_valid, out_pc, out_instr, word_at(2)); end
  endtask

  task automatic test_stall;
    do_reset(1'b0);
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL stall_head: v=%0b pc=%h want 1/0", out_valid, out_pc); end
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr: got %h want 8", imem_addr); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL stall_pop0: v=%0b pc=%h want 1/0", out_valid, out_pc); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h20090007) begin n_err++; $display("FAIL stall_pop4: v=%0b pc=%h instr=%h want 1/4/20090007", out_valid, out_pc, out_instr); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== word_at(2)) begin n_err++; $display("FAIL stall_pop8: v=%0b pc=%h instr=%h want 1/8/%h", out_valid, out_pc, out_instr, word_at(2)); end
  endtask

  task automatic test_redirect;
    do_reset(1'b1);
    repeat (5) tick();
    n_cmp++; if (out_pc !== 32'h10) begin n_err++; $display("FAIL redir_setup: pc got %h want 10", out_pc); end
    out_ready = 1'b0;
    tick();
    n_cmp++; if (imem_addr !== 32'h18 || out_pc !== 32'h10) begin n_err++; $display("FAIL redir_full: addr=%h pc=%h want 18/10", imem_addr, out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h28;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_mask: valid got %0b want 0", out_valid); end
    tick();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || imem_addr !== 32'h28) begin n_err++; $display("FAIL redir_flush: v=%0b addr=%h want 0/28", out_valid, imem_addr); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h28 || out_instr !== word_at(10)) begin n_err++; $display("FAIL redir_first: v=%0b pc=%h instr=%h want 1/28/%h", out_valid, out_pc, out_instr, word_at(10)); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h2C) begin n_err++; $display("FAIL redir_next: v=%0b pc=%h want 1/2c", out_valid, out_pc); end
  endtask

  task automatic test_fault_end;
    do_reset(1'b1);
    for (int k = 1; k <= 128; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 1))) begin n_err++; $display("FAIL seq_%0d: v=%0b pc=%h want 1/%h", k, out_valid, out_pc, 32'(4 * (k - 1))); end
    end
    n_cmp++; if (out_instr !== word_at(127) || fetch_fault !== 1'b0) begin n_err++; $display("FAIL end_word: instr=%h fault=%0b want %h/0", out_instr, fetch_fault, word_at(127)); end
    tick();
    n_cmp++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h200) begin n_err++; $display("FAIL end_fault: f=%0b v=%0b addr=%h want 1/0/200", fetch_fault, out_valid, imem_addr); end
    tick();
    n_cmp++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h200) begin n_err++; $display("FAIL end_hold: f=%0b v=%0b addr=%h want 1/0/200", fetch_fault, out_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL end_recover: f=%0b v=%0b want 0/0", fetch_fault, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00004020) begin n_err++; $display("FAIL end_refetch: v=%0b pc=%h instr=%h want 1/0/00004020", out_valid, out_pc, out_instr); end
  endtask

  task automatic test_fault_drain;
    do_reset(1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h1F8;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (fetch_fault !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h1F8) begin n_err++; $display("FAIL drain_full: f=%0b v=%0b pc=%h want 1/1/1f8", fetch_fault, out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h1FC || out_instr !== word_at(127)) begin n_err++; $display("FAIL drain_last: v=%0b pc=%h instr=%h want 1/1fc/%h", out_valid, out_pc, out_instr, word_at(127)); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || fetch_fault !== 1'b1) begin n_err++; $display("FAIL drain_empty: v=%0b f=%0b want 0/1", out_valid, fetch_fault); end
  endtask

  task automatic test_misaligned;
    do_reset(1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_mask: valid got %0b want 0", out_valid); end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h6) begin n_err++; $display("FAIL mis_fault: f=%0b v=%0b addr=%h want 1/0/6", fetch_fault, out_valid, imem_addr); end
    tick();
    n_cmp++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h6) begin n_err++; $display("FAIL mis_hold: f=%0b v=%0b addr=%h want 1/0/6", fetch_fault, out_valid, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_fault !== 1'b1 || imem_addr !== 32'h400) begin n_err++; $display("FAIL range_fault: f=%0b addr=%h want 1/400", fetch_fault, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL mis_recover: f=%0b v=%0b want 0/0", fetch_fault, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_instr !== word_at(2)) begin n_err++; $display("FAIL mis_refetch: v=%0b pc=%h instr=%h want 1/8/%h", out_valid, out_pc, out_instr, word_at(2)); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    repeat (3) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL rmid_full: v=%0b pc=%h want 1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || fetch_fault !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rmid_async: v=%0b f=%0b pc=%h instr=%h addr=%h want all 0", out_valid, fetch_fault, out_pc, out_instr, imem_addr); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle: valid got %0b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00004020) begin n_err++; $display("FAIL rmid_first: v=%0b pc=%h instr=%h want 1/0/00004020", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = word_at(i);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault_end();
    test_fault_drain();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
